hadamard_addnorm_2: RTL and testbench
=====================================

Name: hadamard_addnorm_2

Overview:
- Downstream neighbour of the 2-lane mantissa alignment shifter in the Hadamard datapath.
- Takes two exponent-aligned sign-magnitude mantissa words plus their shared max exponent, and forms the 2-point butterfly y0 = a+b, y1 = a-b.
- Normalizes, rounds (RNE) and repacks both results to the {sign, exp, man} minifloat format.
- 3-stage pipeline with valid/ready handshake.

Parameters:
- expWidth, 3, exponent field width
- sigWidth, 3, stored mantissa width (hidden 1 not stored)
- low_expand, 2, extra low-order guard bits carried by aligned words

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- man_off  input  2*W, W=sigWidth+4+low_expand  word i at [W*(i+1)-1 : W*i]; MSB = sign, lower W-1 bits = magnitude
- op_zero  input  2  op_zero[i]=1 means operand i is zero; its magnitude is ignored
- max_exp  input  expWidth  shared exponent of the aligned words
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- y  output  2*(1+expWidth+sigWidth)  y0 in the low half, y1 in the high half; each {sign, exp, man}

Behaviour:
- Magnitude: H = sigWidth+low_expand. Bit H has weight 2^max_exp; the top 2 bits are headroom.
- Reset: out_valid=0, y=0, all stage valids=0. Reset is asynchronous; an in-flight beat is discarded, and no output is produced for it after release.
- Handshake:
  - en = !out_valid | out_ready; in_ready = en.
  - All three stages advance together when en=1 and freeze when en=0.
  - A beat is accepted when in_valid & in_ready. Bubbles are not collapsed.
- Latency: exactly 3 cycles from accept to out_valid with out_ready held high. Throughput 1 beat per cycle.
- While out_valid=1 & out_ready=0, y and out_valid stay stable.
- S1, add/sub:
  - Convert each operand to two's complement, width W+1; a zero operand contributes 0.
  - S0 = A+B, S1 = A-B.
- S2, abs + leading-one detect:
  - Record sign = MSB of S; |S| is at most W bits.
  - p = position of the leading one in |S| (0..H+2).
  - zero flag = (|S|==0).
- S3, normalize/round/pack:
  - e = max_exp + p - H, computed signed with width expWidth+2.
  - man = sigWidth bits below the leading one; guard = next bit; sticky = OR of all remaining bits. Missing low bits read as 0.
  - RNE: increment if guard & (sticky | man[0]).
  - Mantissa carry-out: man=0, e=e+1.
- Special cases:
  - zero result → all-zero word (sign 0).
  - e > 2^expWidth-1 → saturate to {sign, all ones, all ones}.
  - e < 1 → flush to {sign, 0, 0}. There are no subnormals.
- Both lanes are always computed in the same beat. Saturation and flush are decided per lane.

Decomposition:
- Shared package holds:
  - W and H width expressions
  - the packed minifloat word width
  - the max encoded exponent constant
  - the round-decision helper function
- Instantiate one sub-module twice: hadamard_norm_round, covering LZD, normalize shift, RNE and pack for one lane (S2+S3 logic).
- The top level holds S1, the pipeline registers and the handshake.

Test Plan (expWidth=3, sigWidth=3, low_expand=2, so W=9 and the magnitude is 8 bits):
- a=0x020, b=0x020, max_exp=3, op_zero=0 → 3 cycles later y0={0,100,000}, y1=0 (exact cancel).
- a=0x020, b=0x010, max_exp=3 → y0={0,011,100} (1.5×8), y1={0,010,000}.
- a=0x03C, b=0x002, max_exp=3 → y0 rounds up with carry {0,100,000}; y1={0,011,110} (tie, lsb even, no round).
- Two cases with max_exp=7:
  - a=b=0x03C → y0 saturates {0,111,111}, y1=0.
  - a=0x020, b=sign-set 0x020 → y0=0, y1={0,111,111}.
- Backpressure: stream 4 beats, drop out_ready for 3 cycles after the first result → y/out_valid held stable, in_ready=0 while stalled, all 4 results delivered in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rstn=0 for 1 cycle → out_valid drops immediately, neither beat emerges, and the next accepted beat appears with 3-cycle latency.

Source files
------------

// File: rtl/hadamard_addnorm_2_pkg.sv
// Shared widths, constants and the round-to-nearest-even decision
// for the 2-point Hadamard add/normalize stage.
package hadamard_addnorm_2_pkg;

  localparam int LANES = 2;

  // Aligned word: sign + 2 headroom bits + hidden one + stored mantissa + guard bits
  function automatic int mag_w(input int sig_w, input int low_exp);
    return sig_w + 4 + low_exp;
  endfunction

  function automatic int hid_pos(input int sig_w, input int low_exp);
    return sig_w + low_exp;
  endfunction

  function automatic int word_w(input int exp_w, input int sig_w);
    return 1 + exp_w + sig_w;
  endfunction

  function automatic int max_enc_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/hadamard_norm_round.sv
// One butterfly lane: abs + leading-one detect on the raw sum, and
// normalize/round/pack on the registered result of that detect.
module hadamard_norm_round
  import hadamard_addnorm_2_pkg::*;
#(
  parameter int expWidth   = 3,
  parameter int sigWidth   = 3,
  parameter int low_expand = 2,
  localparam int W    = mag_w(sigWidth, low_expand),
  localparam int PW   = $clog2(W),
  localparam int WORD = word_w(expWidth, sigWidth)
) (
  input  logic [W:0]          sum,
  output logic                sum_sign,
  output logic [PW-1:0]       sum_lead,
  output logic                sum_zero,
  output logic [W-1:0]        sum_mag,
  input  logic                lane_sign,
  input  logic [PW-1:0]       lane_lead,
  input  logic                lane_zero,
  input  logic [W-1:0]        lane_mag,
  input  logic [expWidth-1:0] lane_exp,
  output logic [WORD-1:0]     word
);

  localparam int H   = hid_pos(sigWidth, low_expand);
  localparam int NW  = W - 1;
  localparam int EW2 = expWidth + 2;
  localparam int MR  = sigWidth + 1;
  localparam logic [PW-1:0]         TOP  = PW'(NW);
  localparam logic signed [EW2-1:0] EMAX = EW2'(max_enc_exp(expWidth));
  localparam logic signed [EW2-1:0] ONE  = EW2'(1);

  logic [NW-1:0]         norm;
  logic [sigWidth-1:0]   man;
  logic                  guard;
  logic                  sticky;
  logic [MR-1:0]         man_r;
  logic signed [EW2-1:0] exp_s;

  always_comb begin : lzd
    sum_sign = sum[W];
    sum_mag  = sum[W] ? W'(-sum) : W'(sum);
    sum_zero = (sum_mag == '0);
    sum_lead = '0;
    for (int i = 0; i < W; i++) begin
      if (sum_mag[i]) sum_lead = PW'(i);
    end
  end

  // Leading one is shifted out of the top so norm holds only the bits below it
  always_comb begin : normalize
    norm   = NW'(lane_mag << (TOP - lane_lead));
    man    = norm[NW-1 -: sigWidth];
    guard  = norm[NW-1-sigWidth];
    sticky = |norm[NW-2-sigWidth:0];
    man_r  = {1'b0, man} + MR'(rne_inc(guard, sticky, man[0]));
    exp_s  = EW2'(lane_exp) + EW2'(lane_lead) - EW2'(H) + EW2'(man_r[sigWidth]);
    if (lane_zero) begin
      word = '0;
    end else if (exp_s > EMAX) begin
      word = {lane_sign, {expWidth{1'b1}}, {sigWidth{1'b1}}};
    end else if (exp_s < ONE) begin
      word = {lane_sign, {(expWidth + sigWidth){1'b0}}};
    end else begin
      word = {lane_sign, exp_s[expWidth-1:0], man_r[sigWidth-1:0]};
    end
  end

endmodule

// File: rtl/hadamard_addnorm_2.sv
// 2-point Hadamard butterfly on aligned sign-magnitude words, normalized,
// RNE-rounded and packed to minifloat through a 3-stage stallable pipeline.
module hadamard_addnorm_2
  import hadamard_addnorm_2_pkg::*;
#(
  parameter int expWidth   = 3,
  parameter int sigWidth   = 3,
  parameter int low_expand = 2,
  localparam int W    = mag_w(sigWidth, low_expand),
  localparam int WORD = word_w(expWidth, sigWidth)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*W-1:0]        man_off,
  input  logic [1:0]            op_zero,
  input  logic [expWidth-1:0]   max_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WORD-1:0]     y
);

  localparam int PW = $clog2(W);

  logic en;
  logic [LANES-1:0][W:0] opnd;

  logic                  s1_valid_d, s1_valid_q;
  logic [LANES-1:0][W:0] s1_res_d, s1_res_q;
  logic [expWidth-1:0]   s1_exp_d, s1_exp_q;

  logic                       s2_valid_d, s2_valid_q;
  logic [LANES-1:0]           s2_sign_d, s2_sign_q;
  logic [LANES-1:0]           s2_zero_d, s2_zero_q;
  logic [LANES-1:0][PW-1:0]   s2_lead_d, s2_lead_q;
  logic [LANES-1:0][W-1:0]    s2_mag_d, s2_mag_q;
  logic [expWidth-1:0]        s2_exp_d, s2_exp_q;

  logic              out_valid_d, out_valid_q;
  logic [2*WORD-1:0] y_d, y_q;

  logic          nr_sign [LANES];
  logic [PW-1:0] nr_lead [LANES];
  logic          nr_zero [LANES];
  logic [W-1:0]  nr_mag  [LANES];
  logic [WORD-1:0] nr_word [LANES];

  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    hadamard_norm_round #(
      .expWidth   (expWidth),
      .sigWidth   (sigWidth),
      .low_expand (low_expand)
    ) u_norm_round (
      .sum       (s1_res_q[lane]),
      .sum_sign  (nr_sign[lane]),
      .sum_lead  (nr_lead[lane]),
      .sum_zero  (nr_zero[lane]),
      .sum_mag   (nr_mag[lane]),
      .lane_sign (s2_sign_q[lane]),
      .lane_lead (s2_lead_q[lane]),
      .lane_zero (s2_zero_q[lane]),
      .lane_mag  (s2_mag_q[lane]),
      .lane_exp  (s2_exp_q),
      .word      (nr_word[lane])
    );
  end

  // A flagged-zero operand contributes nothing regardless of its magnitude bits
  always_comb begin : to_twos
    for (int i = 0; i < LANES; i++) begin
      opnd[i] = '0;
      if (!op_zero[i]) begin
        opnd[i] = man_off[W*i+W-1] ? -{2'b00, man_off[W*i +: W-1]}
                                   :  {2'b00, man_off[W*i +: W-1]};
      end
    end
  end

  always_comb begin : pipe_next
    en          = !out_valid_q | out_ready;
    s1_valid_d  = s1_valid_q;
    s1_res_d    = s1_res_q;
    s1_exp_d    = s1_exp_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_lead_d   = s2_lead_q;
    s2_mag_d    = s2_mag_q;
    s2_exp_d    = s2_exp_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_res_d[0] = opnd[0] + opnd[1];
        s1_res_d[1] = opnd[0] - opnd[1];
        s1_exp_d    = max_exp;
      end
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++) begin
          s2_sign_d[i] = nr_sign[i];
          s2_zero_d[i] = nr_zero[i];
          s2_lead_d[i] = nr_lead[i];
          s2_mag_d[i]  = nr_mag[i];
        end
        s2_exp_d = s1_exp_q;
      end
      if (s2_valid_q) begin
        for (int i = 0; i < LANES; i++) begin
          y_d[i*WORD +: WORD] = nr_word[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_res_q    <= '0;
      s1_exp_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= '0;
      s2_zero_q   <= '0;
      s2_lead_q   <= '0;
      s2_mag_q    <= '0;
      s2_exp_q    <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_res_q    <= s1_res_d;
      s1_exp_q    <= s1_exp_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_lead_q   <= s2_lead_d;
      s2_mag_q    <= s2_mag_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_hadamard_addnorm_2.sv
// Directed vector table plus backpressure and reset sequences for
// the Hadamard add/normalize pipeline (expWidth=3, sigWidth=3, low_expand=2).
module tb_hadamard_addnorm_2;

  localparam int EW   = 3;
  localparam int SW   = 3;
  localparam int LE   = 2;
  localparam int W    = SW + 4 + LE;
  localparam int WORD = 1 + EW + SW;
  localparam int NV   = 14;

  typedef struct {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [1:0]      zero;
    logic [EW-1:0]   mexp;
    logic [WORD-1:0] y0;
    logic [WORD-1:0] y1;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic [2*W-1:0]    man_off;
  logic [1:0]        op_zero;
  logic [EW-1:0]     max_exp;
  logic              out_valid;
  logic              out_ready;
  logic [2*WORD-1:0] y;

  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs [NV];

  hadamard_addnorm_2 #(
    .expWidth   (EW),
    .sigWidth   (SW),
    .low_expand (LE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .man_off   (man_off),
    .op_zero   (op_zero),
    .max_exp   (max_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveBeat(input vec_t v);
    man_off  = {v.b, v.a};
    op_zero  = v.zero;
    max_exp  = v.mexp;
    in_valid = 1'b1;
  endtask

  // Sends one beat with out_ready high; lat counts clock edges from the accepting edge to out_valid
  task automatic applyStimulus(input vec_t v, output int lat);
    int waits = 0;
    @(negedge clk);
    out_ready = 1'b1;
    driveBeat(v);
    #1;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    checkOutput("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int sent;
    int cyc;
    int stall_left;
    int extra;
    int ghost;
    int waits;
    bit stall_done;
    logic [2*WORD-1:0] held;
    logic [2*WORD-1:0] rx [$];

    //          a       b       zero  mexp  y0     y1
    vecs[0]  = '{9'h020, 9'h020, 2'b00, 3'd3, 7'h20, 7'h00};
    vecs[1]  = '{9'h020, 9'h010, 2'b00, 3'd3, 7'h1C, 7'h10};
    vecs[2]  = '{9'h03C, 9'h002, 2'b00, 3'd3, 7'h20, 7'h1E};
    vecs[3]  = '{9'h03C, 9'h03C, 2'b00, 3'd7, 7'h3F, 7'h00};
    vecs[4]  = '{9'h020, 9'h120, 2'b00, 3'd7, 7'h00, 7'h3F};
    vecs[5]  = '{9'h020, 9'h018, 2'b01, 3'd3, 7'h14, 7'h54};
    vecs[6]  = '{9'h010, 9'h030, 2'b00, 3'd4, 7'h28, 7'h60};
    vecs[7]  = '{9'h020, 9'h01F, 2'b00, 3'd1, 7'h10, 7'h00};
    vecs[8]  = '{9'h020, 9'h003, 2'b00, 3'd3, 7'h19, 7'h16};
    vecs[9]  = '{9'h1FF, 9'h0AB, 2'b11, 3'd5, 7'h00, 7'h00};
    vecs[10] = '{9'h020, 9'h000, 2'b00, 3'd7, 7'h38, 7'h38};
    vecs[11] = '{9'h03F, 9'h000, 2'b00, 3'd7, 7'h3F, 7'h3F};
    vecs[12] = '{9'h020, 9'h000, 2'b00, 3'd1, 7'h08, 7'h08};
    vecs[13] = '{9'h040, 9'h040, 2'b00, 3'd0, 7'h10, 7'h00};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    man_off   = '0;
    op_zero   = '0;
    max_exp   = '0;
    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_y", 32'(y), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    for (int k = 0; k < NV; k++) begin
      applyStimulus(vecs[k], lat);
      checkOutput($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
      checkOutput($sformatf("v%0d_y0", k), 32'(y[WORD-1:0]), 32'(vecs[k].y0));
      checkOutput($sformatf("v%0d_y1", k), 32'(y[2*WORD-1:WORD]), 32'(vecs[k].y1));
    end

    // Backpressure: four back-to-back beats, out_ready low for 3 cycles after the first result
    @(negedge clk);
    in_valid   = 1'b0;
    sent       = 0;
    cyc        = 0;
    stall_left = 0;
    stall_done = 1'b0;
    held       = '0;
    while (rx.size() < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (sent < 4) driveBeat(vecs[sent]);
      else in_valid = 1'b0;
      #1;
      if (stall_left > 0) begin
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        if (stall_left == 3) held = y;
        else checkOutput("stall_y_hold", 32'(y), 32'(held));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        rx.push_back(y);
        if (!stall_done) begin
          stall_done = 1'b1;
          stall_left = 3;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_count", 32'(rx.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx.size(); k++) begin
      checkOutput($sformatf("bp_order%0d", k), 32'(rx[k]), 32'({vecs[k].y1, vecs[k].y0}));
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checkOutput("bp_no_dup", 32'(extra), 32'd0);

    // Reset with two beats in flight: neither may emerge afterwards
    @(negedge clk);
    driveBeat(vecs[1]);
    @(negedge clk);
    driveBeat(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    @(negedge clk);
    rstn  = 1'b1;
    ghost = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    checkOutput("rst_no_ghost", 32'(ghost), 32'd0);
    applyStimulus(vecs[6], lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd3);
    checkOutput("post_rst_y", 32'(y), 32'({vecs[6].y1, vecs[6].y0}));

    // Reset asserted mid-cycle while a stalled result is held must clear it at once
    @(negedge clk);
    out_ready = 1'b0;
    driveBeat(vecs[8]);
    @(negedge clk);
    in_valid = 1'b0;
    waits    = 0;
    while (!out_valid && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_y", 32'(y), 32'({vecs[8].y1, vecs[8].y0}));
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_y", 32'(y), 32'd0);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    applyStimulus(vecs[11], lat);
    checkOutput("final_latency", 32'(lat), 32'd3);
    checkOutput("final_y", 32'(y), 32'({vecs[11].y1, vecs[11].y0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
